// File: rtl/div_pkg.sv
// Shared encodings for the iterative divide/remainder unit.
// Op codes follow the M-extension funct3 low bits used by the decoder.
package div_pkg;

    typedef logic [1:0] div_op_t;
    typedef logic [1:0] div_state_t;

    localparam div_op_t OP_DIV  = 2'b00;
    localparam div_op_t OP_DIVU = 2'b01;
    localparam div_op_t OP_REM  = 2'b10;
    localparam div_op_t OP_REMU = 2'b11;

    localparam div_state_t S_IDLE = 2'b00;
    localparam div_state_t S_CALC = 2'b01;
    localparam div_state_t S_FIX  = 2'b10;
    localparam div_state_t S_DONE = 2'b11;

    localparam int DIV_LATENCY = 34;

endpackage

// File: rtl/div_if.sv
// Launch/result handshake between execute-stage control and the divider.
interface div_if
    import div_pkg::*;
#(
    parameter int WIDTH = 32
);

    logic             start;
    div_op_t          op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (output start, op, A, B, input busy, done, result);
    modport slave  (input start, op, A, B, output busy, done, result);

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, try the subtract.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           borrow;
    logic           fits;

    assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign {borrow, trial} = {1'b0, shifted} - {2'b00, divisor};

    // A set rem MSB means the shifted value exceeds any divisor, so it always fits.
    assign fits = rem[WIDTH] | ~borrow;

    assign rem_next = fits ? trial : shifted;
    assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU/REM/REMU: magnitudes are divided unsigned over WIDTH
// cycles, then signs are reapplied in a single fix-up cycle.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic  clk,
    input logic  rst_n,
    div_if.slave bus
);

    localparam int               CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    logic [CW-1:0]    count;
    logic             sel_rem;
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;

    logic             op_signed;
    logic             op_rem;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH-1:0] special_result;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] x);
        return ~x + ONE;
    endfunction

    assign op_signed = (bus.op == OP_DIV) || (bus.op == OP_REM);
    assign op_rem    = (bus.op == OP_REM) || (bus.op == OP_REMU);

    // The most negative value negates to itself, which is its correct unsigned magnitude.
    assign a_neg = op_signed & bus.A[WIDTH-1];
    assign b_neg = op_signed & bus.B[WIDTH-1];
    assign a_mag = a_neg ? twos_neg(bus.A) : bus.A;
    assign b_mag = b_neg ? twos_neg(bus.B) : bus.B;

    assign div_zero = (bus.B == '0);
    assign overflow = op_signed && (bus.A == MIN_NEG) && (bus.B == '1);

    always_comb begin
        special_result = '0;
        if (div_zero) begin
            special_result = op_rem ? bus.A : '1;
        end else begin
            special_result = op_rem ? '0 : MIN_NEG;
        end
    end

    assign q_fix = q_neg ? twos_neg(quo) : quo;
    assign r_fix = r_neg ? twos_neg(rem[WIDTH-1:0]) : rem[WIDTH-1:0];

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (rem),
        .quo     (quo),
        .divisor (divisor),
        .rem_next(rem_next),
        .quo_next(quo_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            count      <= '0;
            sel_rem    <= 1'b0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            rem        <= '0;
            quo        <= '0;
            divisor    <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        sel_rem <= op_rem;
                        if (div_zero || overflow) begin
                            bus.result <= special_result;
                            bus.done   <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            quo      <= a_mag;
                            divisor  <= b_mag;
                            rem      <= '0;
                            q_neg    <= a_neg ^ b_neg;
                            r_neg    <= a_neg;
                            count    <= LAST;
                            bus.busy <= 1'b1;
                            state    <= S_CALC;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count - CNT_ONE;
                    if (count == '0) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    bus.result <= sel_rem ? r_fix : q_fix;
                    bus.done   <= 1'b1;
                    bus.busy   <= 1'b0;
                    state      <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against a plain-arithmetic reference.
module tb_div_unit;
    import div_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    div_if #(.WIDTH(32)) bus ();

    div_unit #(
        .WIDTH(32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        bit signedOp;
        bit remOp;
        int sa;
        int sb;
        signedOp = (op == 2'b00) || (op == 2'b10);
        remOp    = (op == 2'b10) || (op == 2'b11);
        sa = a;
        sb = b;
        if (b == 32'd0) return remOp ? a : 32'hFFFF_FFFF;
        if (signedOp && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return remOp ? 32'd0 : 32'h8000_0000;
        if (signedOp) return remOp ? 32'(sa % sb) : 32'(sa / sb);
        return remOp ? (a % b) : (a / b);
    endfunction

    function automatic int refLatency(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        bit signedOp;
        signedOp = (op == 2'b00) || (op == 2'b10);
        if (b == 32'd0) return 1;
        if (signedOp && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge of cycle 1.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    task automatic waitDone(input int startCycle, output int lat, output int busyCnt);
        lat     = startCycle;
        busyCnt = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            if (bus.busy === 1'b1) busyCnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        int lat;
        int busyCnt;
        int expLat;
        expLat = refLatency(op, a, b);
        applyStimulus(op, a, b);
        waitDone(1, lat, busyCnt);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "_busycycles"}, 32'(busyCnt), 32'(expLat - 1));
        checkOutput({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_result"}, bus.result, refResult(op, a, b));
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int lat;
        int busyCnt;
        int doneCnt;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = OP_DIVU;
        bus.A     = '0;
        bus.B     = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_result", bus.result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        runOp(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
        runOp(OP_REMU, 32'd100, 32'd7, "remu_100_7");
        runOp(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        runOp(OP_REM, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        runOp(OP_DIV, 32'd5, 32'd0, "div_by_zero");
        runOp(OP_REMU, 32'd5, 32'd0, "remu_by_zero");
        runOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        runOp(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow");
        runOp(OP_DIVU, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
        runOp(OP_DIV, 32'h8000_0000, 32'd3, "div_minneg_3");

        // A start during CALC must be dropped; one on the done cycle must launch.
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.A     = 32'd9;
        bus.B     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(11, lat, busyCnt);
        checkOutput("ignored_start_latency", 32'(lat), 32'd34);
        checkOutput("ignored_start_result", bus.result, 32'd14);
        applyStimulus(OP_DIVU, 32'd9, 32'd3);
        waitDone(1, lat, busyCnt);
        checkOutput("b2b_latency", 32'(lat), 32'd34);
        checkOutput("b2b_busycycles", 32'(busyCnt), 32'd33);
        checkOutput("b2b_result", bus.result, 32'd3);
        @(negedge clk);

        // Reset in the middle of CALC aborts without a later done pulse.
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
        checkOutput("midreset_done", 32'(bus.done), 32'd0);
        checkOutput("midreset_result", bus.result, 32'd0);
        rst_n   = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) doneCnt++;
        end
        checkOutput("midreset_no_done", 32'(doneCnt), 32'd0);
        runOp(OP_DIVU, 32'd8, 32'd2, "after_reset_divu_8_2");

        for (int n = 0; n < 24; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'd0 - 32'($urandom_range(1, 15));
                3: begin
                    ra = 32'h8000_0000;
                    rb = 32'hFFFF_FFFF;
                end
                4: begin
                    ra = 32'($urandom_range(0, 1000));
                    rb = 32'($urandom_range(1, 1000));
                end
                default: rb = $urandom;
            endcase
            runOp(rop, ra, rb, $sformatf("rand%0d_op%0d_%h_%h", n, rop, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit integer divide/remainder unit; the inverse companion to the ALU's single-cycle MUL.
- Implements RISC-V M-extension DIV, DIVU, REM and REMU semantics.
- Sits beside the ALU in the execute stage.
- Control logic launches an operation with a start pulse, stalls on busy, and captures result on the done pulse.

Parameters:
WIDTH  32  operand/result width; iteration count equals WIDTH.

Ports:
clk     input   1      rising-edge clock
rst_n   input   1      synchronous reset, active-low
start   input   1      launch request; sampled only in IDLE or DONE
op      input   2      00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start
A       input   WIDTH  dividend; sampled with start
B       input   WIDTH  divisor; sampled with start
busy    output  1      1 while in CALC or FIX
done    output  1      single-cycle pulse; result valid this cycle
result  output  WIDTH  quotient or remainder; held until next accepted start

Behaviour:
- Reset: rst_n low at a clock edge forces:
  - state IDLE
  - busy=0, done=0, result=0
  - all internal registers cleared
- Reset mid-operation aborts the operation; no done pulse follows.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start=1 (acceptance cycle 0): latch op, A, B.
  - Divide-by-zero (B==0): result = all-ones for DIV/DIVU; A for REM/REMU. Next state DONE.
  - Signed overflow (op DIV/REM, A==0x8000_0000, B==0xFFFF_FFFF): result = 0x8000_0000 for DIV; 0 for REM. Next state DONE.
  - Otherwise:
    - signed ops: store |A|, |B| and sign flags (quotient sign = signA^signB; remainder sign = signA)
    - unsigned ops: use A and B raw
    - clear remainder register, counter=WIDTH-1, go to CALC.
- CALC: one restoring-division step per cycle, for WIDTH cycles (cycles 1..32):
  - shift {rem, quo} left by one, bringing in the dividend MSB
  - trial = rem - divisor
  - if no borrow, rem=trial and quo LSB=1; else quo LSB=0
  - after counter==0, go to FIX.
- FIX (cycle 33): negate quotient/remainder per stored sign flags (signed ops only); load result with the quotient or remainder selected by op; go to DONE.
- DONE: done=1 for exactly one cycle.
  - Normal latency: done in cycle 34 after acceptance.
  - Special-case latency: done in cycle 1.
- DONE with start=0 goes to IDLE. DONE with start=1 accepts a new operation immediately (back-to-back, no bubble).
- start while busy=1 is ignored; latched operands are unaffected.
- Width rules:
  - Remainder register is WIDTH+1 bits so the trial-subtraction borrow is observable.
  - Negation is two's complement (~x+1) truncated to WIDTH.
  - |0x8000_0000| is 0x8000_0000 treated as unsigned; valid for the non-overflow signed cases.
- Outputs registered; no combinational path from inputs to busy, done or result.

Decomposition:
- Shared package div_pkg:
  - op encodings: OP_DIV, OP_DIVU, OP_REM, OP_REMU
  - state encoding: S_IDLE, S_CALC, S_FIX, S_DONE
  - constant DIV_LATENCY=34
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once in CALC.
- FSM, counter and sign handling stay in div_unit.

Test Plan:
- DIVU A=100, B=7 -> busy high cycles 1..33; done pulse cycle 34; result=14. Repeat as REMU -> result=2.
- DIV A=-7 (0xFFFF_FFF9), B=2 -> result=0xFFFF_FFFD (-3). REM same operands -> result=0xFFFF_FFFF (-1). Signs follow dividend, truncation toward zero.
- Divide by zero:
  - DIV A=5, B=0 -> done in cycle 1, result=0xFFFF_FFFF
  - REMU A=5, B=0 -> result=5
- Overflow: DIV A=0x8000_0000, B=0xFFFF_FFFF -> done cycle 1, result=0x8000_0000. REM same operands -> result=0.
- Start while busy: start DIVU 100/7; assert start with A=9, B=3 at cycle 10 -> ignored, result=14 at cycle 34. Assert start with DIVU 9/3 on the done cycle -> accepted; second done 34 cycles later with result=3.
- Reset mid-operation: drive rst_n=0 at cycle 15 of a DIVU -> next cycle busy=0, done=0, result=0; no done pulse afterwards. A new DIVU 8/2 after reset -> result=4.
